// File: rtl/cell_draw_arbiter.sv
// Round-robin arbiter that paints one board cell per grant through the shared pixel-plot path.
// Optional CELL_ARB_GRID_EN: first row/column of every cell is drawn with select=2'b11 (grid line).
module cell_draw_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int CELL_SIZE = 12,
    parameter int ORIGIN_X  = 32,
    parameter int ORIGIN_Y  = 12,
    parameter int BOARD_DIM = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_x,
    input  logic [3*NUM_REQ-1:0]   req_y,
    input  logic [2*NUM_REQ-1:0]   req_sel,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [7:0]             x_plot,
    output logic [6:0]             y_plot,
    output logic [1:0]             select,
    output logic                   plot
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CELL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t               state_q;
    logic [IW-1:0]        lastWin_q;
    logic [CW-1:0]        col_q, row_q;
    logic [2:0]           cx_q, cy_q;
    logic [1:0]           sel_q;
    logic [NUM_REQ-1:0]   gnt_q, done_q;
    logic                 busy_q, plot_q;
    logic [7:0]           x_q;
    logic [6:0]           y_q;
    logic [1:0]           select_q;

    logic                 winValid, winInBoard;
    logic [IW-1:0]        winIdx;
    logic [2:0]           winX, winY, srcX, srcY;
    logic [1:0]           winSel, srcSel, pixSel;
    logic [CW-1:0]        pixCol, pixRow;
    logic [7:0]           pixX;
    logic [6:0]           pixY;
    logic [NUM_REQ-1:0]   reqRot;
    int                   cand;

    // Winner search and the coordinates of the pixel to be shown next cycle
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        reqRot   = '0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand   = (int'(lastWin_q) + 1 + i) % NUM_REQ;
            reqRot = req >> cand;
            if (!winValid && reqRot[0]) begin
                winValid = 1'b1;
                winIdx   = IW'(cand);
            end
        end
        winX       = 3'(req_x >> (3 * int'(winIdx)));
        winY       = 3'(req_y >> (3 * int'(winIdx)));
        winSel     = 2'(req_sel >> (2 * int'(winIdx)));
        winInBoard = (int'(winX) < BOARD_DIM) && (int'(winY) < BOARD_DIM);

        if (state_q == IDLE) begin
            srcX   = winX;
            srcY   = winY;
            srcSel = winSel;
            pixCol = '0;
            pixRow = '0;
        end else begin
            srcX   = cx_q;
            srcY   = cy_q;
            srcSel = sel_q;
            if (col_q == LAST) begin
                pixCol = '0;
                pixRow = row_q + 1'b1;
            end else begin
                pixCol = col_q + 1'b1;
                pixRow = row_q;
            end
        end

        pixX = 8'(ORIGIN_X + int'(srcX) * CELL_SIZE + int'(pixCol));
        pixY = 7'(ORIGIN_Y + int'(srcY) * CELL_SIZE + int'(pixRow));
`ifdef CELL_ARB_GRID_EN
        pixSel = ((pixCol == '0) || (pixRow == '0)) ? 2'b11 : srcSel;
`else
        pixSel = srcSel;
`endif
    end

    // Control FSM; every output is registered and updated here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lastWin_q <= IW'(NUM_REQ - 1);
            col_q     <= '0;
            row_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            select_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winValid) begin
                        lastWin_q <= winIdx;
                        cx_q      <= winX;
                        cy_q      <= winY;
                        sel_q     <= winSel;
                        gnt_q     <= NUM_REQ'(1) << winIdx;
                        busy_q    <= 1'b1;
                        col_q     <= '0;
                        row_q     <= '0;
                        if (winInBoard) begin
                            state_q  <= DRAW;
                            plot_q   <= 1'b1;
                            x_q      <= pixX;
                            y_q      <= pixY;
                            select_q <= pixSel;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DRAW: begin
                    if (col_q == LAST && row_q == LAST) begin
                        plot_q  <= 1'b0;
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end else begin
                        col_q    <= pixCol;
                        row_q    <= pixRow;
                        x_q      <= pixX;
                        y_q      <= pixY;
                        select_q <= pixSel;
                    end
                end
                DONE: begin
                    // A skipped off-board cell arrives here without done raised yet
                    if (done_q == '0) begin
                        done_q <= gnt_q;
                    end else begin
                        done_q  <= '0;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign x_plot = x_q;
    assign y_plot = y_q;
    assign select = select_q;
    assign plot   = plot_q;

endmodule
